// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: instruction geometry and the fetch buffer entry.
package riscv_pkg;

  localparam int RV_XLEN           = 32;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int INSTRUCTION_BYTES = INSTRUCTION_WIDTH / 8;

  typedef struct packed {
    logic [RV_XLEN-1:0]           pc;
    logic [INSTRUCTION_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head is the oldest entry, valid whenever count_o != 0.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [WIDTH-1:0]       head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_d    = wr_q + AW'(push_i);
    rd_d    = rd_q + AW'(pop_i);
    count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with credit-limited requests, prefetch FIFO and redirect flush.
// Optional FETCH_ALIGN_CHECK_EN: pulse fetch_misaligned on a redirect with pc[1:0] != 0.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int               XLEN     = RV_XLEN,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [XLEN-1:0]              imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rsp_data,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [INSTRUCTION_WIDTH-1:0] instr_data,
  output logic [XLEN-1:0]              instr_pc,
  output logic                         fetch_misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTRUCTION_BYTES);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target_pc;
  logic [CW-1:0]   inflight_q, inflight_d, drop_q, drop_d, count;
  logic [CW+1:0]   used;
  logic            req_fire, rsp_keep, rsp_drop, push, pop;
  fetch_entry_t    push_entry, head_entry;

  // Credits: buffered + outstanding (kept or dropped) never exceed the FIFO size.
  assign used           = (CW+2)'(count) + (CW+2)'(inflight_q) + (CW+2)'(drop_q);
  assign imem_req_valid = !rst && !redirect_valid && (used < (CW+2)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop  = imem_rsp_valid && (drop_q != '0);
  assign rsp_keep  = imem_rsp_valid && (drop_q == '0);
  assign push      = rsp_keep && !redirect_valid;
  assign pop       = instr_valid && instr_ready;
  assign target_pc = redirect_pc & ~XLEN'(3);

  assign push_entry.pc    = rsp_pc_q;
  assign push_entry.instr = imem_rsp_data;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      inflight_d = '0;
      drop_d     = drop_q + inflight_q - CW'(rsp_keep) - CW'(rsp_drop);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
      if (rsp_keep) rsp_pc_d   = rsp_pc_q + STEP;
      inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_keep);
      drop_d     = drop_q - CW'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .count_o     (count),
    .head_o      (head_entry)
  );

  // Outputs read zero while empty so the unreset storage never shows through.
  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? head_entry.instr : '0;
  assign instr_pc    = instr_valid ? head_entry.pc : '0;

`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_misaligned = !rst && redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign fetch_misaligned = 1'b0;
`endif

endmodule
